// File: rtl/branch_predict_unit.sv
// Branch resolution unit with a direct-mapped bimodal BHT: combinational fetch-side
// prediction, registered execute-side resolve, mispredict flagging and counter training.
module branch_predict_unit #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] INIT_CTR  = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            bht_flush,
    output logic            ready,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            br_en,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] br_pc,
    input  logic            br_pred_taken,
    input  logic [XLEN-1:0] br_data_a,
    input  logic [XLEN-1:0] br_data_b,
    output logic            res_valid,
    output logic            br_taken,
    output logic            mispredict,
    output logic            br_illegal
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       bht_q [BHT_DEPTH];

    logic             bht_we;
    logic [IDX_W-1:0] bht_waddr;
    logic [1:0]       bht_wdata;

    logic [IDX_W-1:0] pred_idx, br_idx;
    logic             legal, cond_true;
    logic [1:0]       ctr_cur, ctr_next;

    logic res_valid_q, br_taken_q, mispredict_q, br_illegal_q;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign br_idx   = br_pc[IDX_W+1:2];

    // Array read happens before the clocked write, so a same-cycle train is not visible yet.
    assign ready      = (state_q == ST_RUN);
    assign pred_taken = ready & bht_q[pred_idx][1];

    assign legal = (funct3[2:1] != 2'b01);

    always_comb begin
        cond_true = 1'b0;
        case (funct3)
            3'b000:  cond_true = (br_data_a == br_data_b);
            3'b001:  cond_true = (br_data_a != br_data_b);
            3'b100:  cond_true = ($signed(br_data_a) <  $signed(br_data_b));
            3'b101:  cond_true = ($signed(br_data_a) >= $signed(br_data_b));
            3'b110:  cond_true = (br_data_a <  br_data_b);
            3'b111:  cond_true = (br_data_a >= br_data_b);
            default: cond_true = 1'b0;
        endcase
    end

    assign ctr_cur = bht_q[br_idx];

    always_comb begin
        ctr_next = ctr_cur;
        if (cond_true) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bht_we    = 1'b0;
        bht_waddr = idx_q;
        bht_wdata = INIT_CTR;
        if (bht_flush) begin
            state_d = ST_INIT;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    bht_we = 1'b1;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == IDX_W'(BHT_DEPTH - 1)) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (br_en && legal) begin
                        bht_we    = 1'b1;
                        bht_waddr = br_idx;
                        bht_wdata = ctr_next;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Counters need no reset: the init sweep rewrites every entry before RUN.
    always_ff @(posedge clk) begin
        if (rst_n && bht_we) bht_q[bht_waddr] <= bht_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            br_taken_q   <= 1'b0;
            mispredict_q <= 1'b0;
            br_illegal_q <= 1'b0;
        end else begin
            res_valid_q  <= br_en;
            br_taken_q   <= br_en & cond_true;
            mispredict_q <= br_en & legal & (cond_true ^ br_pred_taken);
            br_illegal_q <= br_en & ~legal;
        end
    end

    assign res_valid  = res_valid_q;
    assign br_taken   = br_taken_q;
    assign mispredict = mispredict_q;
    assign br_illegal = br_illegal_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: resolve results go through a scoreboard queue
// checked by an independent monitor; readiness and predictions are checked inline.
module tb_branch_predict_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            bht_flush;
    logic            ready;
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic            br_en;
    logic [2:0]      funct3;
    logic [XLEN-1:0] br_pc;
    logic            br_pred_taken;
    logic [XLEN-1:0] br_data_a;
    logic [XLEN-1:0] br_data_b;
    logic            res_valid;
    logic            br_taken;
    logic            mispredict;
    logic            br_illegal;

    int checks   = 0;
    int failures = 0;

    logic [2:0] exp_q [$];

    branch_predict_unit #(.XLEN(XLEN), .BHT_DEPTH(64), .INIT_CTR(2'b01)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bht_flush    (bht_flush),
        .ready        (ready),
        .pred_pc      (pred_pc),
        .pred_taken   (pred_taken),
        .br_en        (br_en),
        .funct3       (funct3),
        .br_pc        (br_pc),
        .br_pred_taken(br_pred_taken),
        .br_data_a    (br_data_a),
        .br_data_b    (br_data_b),
        .res_valid    (res_valid),
        .br_taken     (br_taken),
        .mispredict   (mispredict),
        .br_illegal   (br_illegal)
    );

    always #5 clk = ~clk;

    // Monitor: {br_taken, mispredict, br_illegal}
    always @(negedge clk) begin
        logic [2:0] got, exp;
        got = {br_taken, mispredict, br_illegal};
        if (res_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result got=%b expected=no result", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL resolve got=%b expected=%b", got, exp);
                end
            end
        end else if (rst_n) begin
            checks++;
            if (got !== 3'b000) begin
                failures++;
                $display("FAIL idle_outputs got=%b expected=000", got);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_pred(input string name, input logic [XLEN-1:0] pc, input logic exp);
        pred_pc = pc;
        #1;
        check(name, {31'd0, pred_taken}, {31'd0, exp});
    endtask

    // exp = {taken, mispredict, illegal}, computed by hand at each call site
    task automatic resolve(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [XLEN-1:0] pc, input logic pred, input logic [2:0] exp);
        br_en = 1'b1;
        funct3 = f3;
        br_data_a = a;
        br_data_b = b;
        br_pc = pc;
        br_pred_taken = pred;
        exp_q.push_back(exp);
        tick();
        br_en = 1'b0;
    endtask

    // Counts edges until ready rises; pred_taken must stay 0 while waiting.
    task automatic wait_ready(input string name, input int exp_cycles);
        int n;
        logic pred_seen;
        n = 0;
        pred_seen = 1'b0;
        while (!ready && n < 200) begin
            if (pred_taken) pred_seen = 1'b1;
            tick();
            n++;
        end
        check(name, n, exp_cycles);
        check({name, "_pred_forced0"}, {31'd0, pred_seen}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; bht_flush = 1'b0; pred_pc = '0; br_en = 1'b0; funct3 = '0;
        br_pc = '0; br_pred_taken = 1'b0; br_data_a = '0; br_data_b = '0;
        tick();
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_res_valid", {31'd0, res_valid}, 32'd0);
        rst_n = 1'b1;
        wait_ready("init_len", 64);

        check_pred("pred_100_init", 32'h100, 1'b0);
        resolve(3'b000, 32'd5, 32'd5, 32'h100, 1'b0, 3'b110);
        check_pred("pred_100_after_beq", 32'h100, 1'b1);

        for (int i = 0; i < 4; i++) resolve(3'b001, 32'd1, 32'd2, 32'h104, 1'b0, 3'b110);
        check_pred("pred_104_sat3", 32'h104, 1'b1);
        resolve(3'b001, 32'd7, 32'd7, 32'h104, 1'b1, 3'b010);
        check_pred("pred_104_ctr2", 32'h104, 1'b1);
        resolve(3'b001, 32'd7, 32'd7, 32'h104, 1'b1, 3'b010);
        check_pred("pred_104_ctr1", 32'h104, 1'b0);

        resolve(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h0A0, 1'b1, 3'b100);
        resolve(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h0A4, 1'b1, 3'b010);
        resolve(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h0A8, 1'b0, 3'b110);
        resolve(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h0AC, 1'b0, 3'b000);
        resolve(3'b000, 32'd3, 32'd4, 32'h0B0, 1'b0, 3'b000);
        resolve(3'b100, 32'd1, 32'hFFFF_FFFF, 32'h0B4, 1'b1, 3'b010);
        resolve(3'b101, 32'd5, 32'd5, 32'h0B8, 1'b1, 3'b100);
        resolve(3'b110, 32'd9, 32'd9, 32'h0BC, 1'b0, 3'b000);
        resolve(3'b111, 32'd0, 32'hFFFF_FFFF, 32'h0A0, 1'b1, 3'b010);

        resolve(3'b010, 32'd0, 32'd0, 32'h100, 1'b1, 3'b001);
        resolve(3'b011, 32'd0, 32'd1, 32'h100, 1'b0, 3'b001);
        check_pred("pred_100_illegal_untrained", 32'h100, 1'b1);

        // Same-cycle lookup and train of index 1 (ctr 01)
        pred_pc = 32'h104;
        br_en = 1'b1; funct3 = 3'b001; br_data_a = 32'd1; br_data_b = 32'd2;
        br_pc = 32'h104; br_pred_taken = 1'b0;
        #1;
        check("rbw_pre_update", {31'd0, pred_taken}, 32'd0);
        exp_q.push_back(3'b110);
        tick();
        br_en = 1'b0;
        check("rbw_post_update", {31'd0, pred_taken}, 32'd1);

        resolve(3'b000, 32'd1, 32'd2, 32'h0C0, 1'b0, 3'b000);
        resolve(3'b000, 32'd1, 32'd2, 32'h0C0, 1'b0, 3'b000);
        check_pred("pred_0c0_sat0", 32'h0C0, 1'b0);
        resolve(3'b000, 32'd3, 32'd3, 32'h0C0, 1'b0, 3'b110);
        check_pred("pred_0c0_ctr1", 32'h0C0, 1'b0);
        resolve(3'b000, 32'd3, 32'd3, 32'h0C0, 1'b0, 3'b110);
        check_pred("pred_0c0_ctr2", 32'h0C0, 1'b1);

        pred_pc = 32'h100;
        bht_flush = 1'b1;
        tick();
        bht_flush = 1'b0;
        check("flush_ready", {31'd0, ready}, 32'd0);
        for (int i = 0; i < 30; i++) tick();
        bht_flush = 1'b1;
        tick();
        bht_flush = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        resolve(3'b000, 32'd9, 32'd9, 32'h100, 1'b0, 3'b110);
        check("init_resolve_ready", {31'd0, ready}, 32'd0);
        wait_ready("flush_tail", 3);
        check_pred("pred_100_after_flush", 32'h100, 1'b0);
        check_pred("pred_104_after_flush", 32'h104, 1'b0);
        check_pred("pred_0c0_after_flush", 32'h0C0, 1'b0);

        resolve(3'b001, 32'd1, 32'd2, 32'h104, 1'b0, 3'b110);
        resolve(3'b001, 32'd1, 32'd2, 32'h104, 1'b0, 3'b110);
        check_pred("pred_104_retrained", 32'h104, 1'b1);
        br_en = 1'b1; funct3 = 3'b000; br_data_a = 32'd4; br_data_b = 32'd4;
        br_pc = 32'h104; br_pred_taken = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        br_en = 1'b0;
        check("midreset_res_valid", {31'd0, res_valid}, 32'd0);
        wait_ready("reset_sweep", 64);
        check_pred("pred_104_after_reset", 32'h104, 1'b0);

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
